// File: rtl/dict_decoder.sv
// dict_decoder: three append-only instruction dictionaries and a one-stage
// registered expander from 32-bit codewords to RV32 instructions.
module dict_decoder #(
  parameter int DICT1_AW = 8,
  parameter int DICT2_AW = 6,
  parameter int DICT3_AW = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dict_clear,
  input  logic        dict1_write_enable,
  input  logic [31:0] dict1_write_val,
  input  logic        dict2_write_enable,
  input  logic [19:0] dict2_write_val,
  input  logic        dict3_write_enable,
  input  logic [15:0] dict3_write_val,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [2:0]  dict_overflow,
  output logic [31:0] cnt_raw,
  output logic [31:0] cnt_d1,
  output logic [31:0] cnt_d2,
  output logic [31:0] cnt_d3
);
  logic [31:0] d1 [2**DICT1_AW];
  logic [19:0] d2 [2**DICT2_AW];
  logic [15:0] d3 [2**DICT3_AW];
  logic [DICT1_AW:0] wp1;
  logic [DICT2_AW:0] wp2;
  logic [DICT3_AW:0] wp3;
  logic [DICT1_AW-1:0] i1;
  logic [DICT2_AW-1:0] i2;
  logic [DICT3_AW-1:0] i3;
  logic [1:0] cls;
  logic acc, hit;
  logic [31:0] val;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  always_comb begin
    cls = in_code[1:0];
    i1 = in_code[DICT1_AW+1:2];
    i2 = in_code[DICT2_AW+1:2];
    i3 = in_code[DICT3_AW+1:2];
    hit = cls == 2'b11 ? 1'b1 :
          cls == 2'b00 ? {1'b0, i1} < wp1 :
          cls == 2'b01 ? {1'b0, i2} < wp2 : {1'b0, i3} < wp3;
    val = cls == 2'b11 ? in_code :
          cls == 2'b00 ? d1[i1] :
          cls == 2'b01 ? {d2[i2], in_code[31:20]} : {d3[i3], in_code[31:16]};
  end
  // Storage is never reset; wp alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (resetn && !dict_clear && dict1_write_enable && !wp1[DICT1_AW]) d1[wp1[DICT1_AW-1:0]] <= dict1_write_val;
    if (resetn && !dict_clear && dict2_write_enable && !wp2[DICT2_AW]) d2[wp2[DICT2_AW-1:0]] <= dict2_write_val;
    if (resetn && !dict_clear && dict3_write_enable && !wp3[DICT3_AW]) d3[wp3[DICT3_AW-1:0]] <= dict3_write_val;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp1 <= '0;
      wp2 <= '0;
      wp3 <= '0;
      dict_overflow <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err <= 1'b0;
      cnt_raw <= '0;
      cnt_d1 <= '0;
      cnt_d2 <= '0;
      cnt_d3 <= '0;
    end else begin
      if (dict_clear) begin
        wp1 <= '0;
        wp2 <= '0;
        wp3 <= '0;
        dict_overflow <= '0;
      end else begin
        if (dict1_write_enable) begin
          if (wp1[DICT1_AW]) dict_overflow[0] <= 1'b1;
          else wp1 <= wp1 + (DICT1_AW+1)'(1);
        end
        if (dict2_write_enable) begin
          if (wp2[DICT2_AW]) dict_overflow[1] <= 1'b1;
          else wp2 <= wp2 + (DICT2_AW+1)'(1);
        end
        if (dict3_write_enable) begin
          if (wp3[DICT3_AW]) dict_overflow[2] <= 1'b1;
          else wp3 <= wp3 + (DICT3_AW+1)'(1);
        end
      end
      if (acc) begin
        out_valid <= 1'b1;
        out_instr <= hit ? val : '0;
        out_err <= !hit;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      cnt_raw <= cnt_raw + {31'b0, acc && cls == 2'b11 && cnt_raw != '1};
      cnt_d1 <= cnt_d1 + {31'b0, acc && cls == 2'b00 && cnt_d1 != '1};
      cnt_d2 <= cnt_d2 + {31'b0, acc && cls == 2'b01 && cnt_d2 != '1};
      cnt_d3 <= cnt_d3 + {31'b0, acc && cls == 2'b10 && cnt_d3 != '1};
    end
  end
endmodule

// File: tb/tb_dict_decoder.sv
// tb_dict_decoder: directed scenario tests for dict_decoder.
module tb_dict_decoder;
  logic clk = 0, resetn = 0, dict_clear = 0;
  logic dict1_write_enable = 0, dict2_write_enable = 0, dict3_write_enable = 0;
  logic [31:0] dict1_write_val = 0;
  logic [19:0] dict2_write_val = 0;
  logic [15:0] dict3_write_val = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, out_err;
  logic [31:0] in_code = 0, out_instr;
  logic [2:0] dict_overflow;
  logic [31:0] cnt_raw, cnt_d1, cnt_d2, cnt_d3;
  int tests = 0, fails = 0;

  dict_decoder dut (
    .clk(clk), .resetn(resetn), .dict_clear(dict_clear),
    .dict1_write_enable(dict1_write_enable), .dict1_write_val(dict1_write_val),
    .dict2_write_enable(dict2_write_enable), .dict2_write_val(dict2_write_val),
    .dict3_write_enable(dict3_write_enable), .dict3_write_val(dict3_write_val),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .dict_overflow(dict_overflow),
    .cnt_raw(cnt_raw), .cnt_d1(cnt_d1), .cnt_d2(cnt_d2), .cnt_d3(cnt_d3)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] code);
    in_valid = 1;
    in_code = code;
    out_ready = 1;
    tick;
    in_valid = 0;
  endtask

  task automatic wr1(input logic [31:0] v);
    dict1_write_enable = 1; dict1_write_val = v; tick; dict1_write_enable = 0;
  endtask

  task automatic test_reset;
    resetn = 0; tick; tick;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (out_instr !== 32'h0 || out_err !== 1'b0) begin fails++; $display("FAIL reset_out got %h/%b exp 0/0", out_instr, out_err); end
    tests++; if (dict_overflow !== 3'b000) begin fails++; $display("FAIL reset_ovf got %b exp 000", dict_overflow); end
    tests++; if ({cnt_raw, cnt_d1, cnt_d2, cnt_d3} !== 128'h0) begin fails++; $display("FAIL reset_cnt got %h %h %h %h exp 0", cnt_raw, cnt_d1, cnt_d2, cnt_d3); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    resetn = 1; tick;
  endtask

  task automatic test_raw;
    send(32'h0000_0513);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL raw_valid got %b exp 1", out_valid); end
    tests++; if (out_instr !== 32'h0000_0513 || out_err !== 1'b0) begin fails++; $display("FAIL raw_out got %h/%b exp 00000513/0", out_instr, out_err); end
    tests++; if (cnt_raw !== 32'd1) begin fails++; $display("FAIL raw_cnt got %0d exp 1", cnt_raw); end
    tick;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL raw_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_dict1;
    wr1(32'h0000_0013); wr1(32'h0011_8193); wr1(32'hFFF0_0293);
    send(32'h0000_0008);
    tests++; if (out_instr !== 32'hFFF0_0293 || out_err !== 1'b0) begin fails++; $display("FAIL d1_hit got %h/%b exp fff00293/0", out_instr, out_err); end
    send(32'h0000_000C);
    tests++; if (out_instr !== 32'h0 || out_err !== 1'b1) begin fails++; $display("FAIL d1_miss got %h/%b exp 00000000/1", out_instr, out_err); end
    tick;
  endtask

  task automatic test_dict23;
    dict2_write_enable = 1; dict2_write_val = 20'h12345; tick; dict2_write_enable = 0;
    send(32'hABC0_0001);
    tests++; if (out_instr !== 32'h1234_5ABC || out_err !== 1'b0) begin fails++; $display("FAIL d2_hit got %h/%b exp 12345abc/0", out_instr, out_err); end
    dict3_write_enable = 1; dict3_write_val = 16'hBEEF; tick; dict3_write_enable = 0;
    send(32'hCAFE_0002);
    tests++; if (out_instr !== 32'hBEEF_CAFE || out_err !== 1'b0) begin fails++; $display("FAIL d3_hit got %h/%b exp beefcafe/0", out_instr, out_err); end
    tick;
  endtask

  task automatic test_overflow;
    dict_clear = 1; tick; dict_clear = 0;
    dict3_write_enable = 1;
    for (int i = 0; i < 256; i++) begin
      dict3_write_val = (i == 0) ? 16'hBEEF : 16'(i);
      tick;
    end
    tests++; if (dict_overflow !== 3'b000) begin fails++; $display("FAIL ovf_full got %b exp 000", dict_overflow); end
    dict3_write_val = 16'h1111; tick; dict3_write_enable = 0;
    tests++; if (dict_overflow !== 3'b100) begin fails++; $display("FAIL ovf_set got %b exp 100", dict_overflow); end
    send(32'h0000_0002);
    tests++; if (out_instr !== 32'hBEEF_0000 || out_err !== 1'b0) begin fails++; $display("FAIL ovf_entry0 got %h/%b exp beef0000/0", out_instr, out_err); end
    send(32'h0000_03FE);
    tests++; if (out_instr !== 32'h00FF_0000 || out_err !== 1'b0) begin fails++; $display("FAIL ovf_last got %h/%b exp 00ff0000/0", out_instr, out_err); end
    tick;
    dict_clear = 1; tick; dict_clear = 0;
    tests++; if (dict_overflow !== 3'b000) begin fails++; $display("FAIL clr_ovf got %b exp 000", dict_overflow); end
    send(32'h0000_0002);
    tests++; if (out_instr !== 32'h0 || out_err !== 1'b1) begin fails++; $display("FAIL clr_lookup got %h/%b exp 00000000/1", out_instr, out_err); end
    tick;
  endtask

  task automatic test_backpressure;
    logic [31:0] codes [4];
    logic rdy [8];
    logic exp_ir [7];
    int sent, rcv;
    codes = '{32'hA000_0003, 32'hA000_0013, 32'hA000_0023, 32'hA000_0033};
    rdy = '{1, 0, 0, 1, 1, 1, 1, 1};
    exp_ir = '{1, 0, 0, 1, 1, 1, 1};
    sent = 0; rcv = 0;
    for (int c = 0; c < 8; c++) begin
      out_ready = rdy[c];
      in_valid = sent < 4;
      in_code = codes[sent < 4 ? sent : 3];
      #1;
      if (c < 7) begin
        tests++; if (in_ready !== exp_ir[c]) begin fails++; $display("FAIL bp_in_ready c%0d got %b exp %b", c, in_ready, exp_ir[c]); end
      end
      if (out_valid && out_ready) begin
        tests++; if (rcv >= 4 || out_instr !== codes[rcv < 4 ? rcv : 3]) begin fails++; $display("FAIL bp_order c%0d got %h exp %h", c, out_instr, codes[rcv < 4 ? rcv : 3]); end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      tick;
    end
    in_valid = 0; out_ready = 1;
    tests++; if (rcv !== 4 || sent !== 4 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_count got rcv %0d sent %0d valid %b exp 4 4 0", rcv, sent, out_valid); end
  endtask

  task automatic test_same_cycle;
    dict_clear = 1; tick; dict_clear = 0;
    dict1_write_enable = 1; dict1_write_val = 32'h0040_0093;
    in_valid = 1; in_code = 32'h0; out_ready = 1;
    tick;
    dict1_write_enable = 0;
    tests++; if (out_instr !== 32'h0 || out_err !== 1'b1) begin fails++; $display("FAIL same_first got %h/%b exp 00000000/1", out_instr, out_err); end
    tick;
    in_valid = 0;
    tests++; if (out_instr !== 32'h0040_0093 || out_err !== 1'b0) begin fails++; $display("FAIL same_second got %h/%b exp 00400093/0", out_instr, out_err); end
    tick;
  endtask

  task automatic test_clear_write;
    dict_clear = 1; dict2_write_enable = 1; dict2_write_val = 20'hFFFFF; tick;
    dict_clear = 0; dict2_write_enable = 0;
    send(32'h0000_0001);
    tests++; if (out_instr !== 32'h0 || out_err !== 1'b1) begin fails++; $display("FAIL clear_wins got %h/%b exp 00000000/1", out_instr, out_err); end
    tick;
  endtask

  task automatic test_counters;
    tests++; if (cnt_raw !== 32'd5 || cnt_d1 !== 32'd4 || cnt_d2 !== 32'd2 || cnt_d3 !== 32'd4) begin fails++; $display("FAIL counters got %0d %0d %0d %0d exp 5 4 2 4", cnt_raw, cnt_d1, cnt_d2, cnt_d3); end
  endtask

  task automatic test_reset_mid;
    send(32'h0000_0033);
    out_ready = 0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_valid got %b exp 1", out_valid); end
    resetn = 0; tick;
    tests++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || cnt_raw !== 32'h0) begin fails++; $display("FAIL mid_reset got %b/%h/%0d exp 0/0/0", out_valid, out_instr, cnt_raw); end
    resetn = 1; out_ready = 1; tick;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_after got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_raw;
    test_dict1;
    test_dict23;
    test_overflow;
    test_backpressure;
    test_same_cycle;
    test_clear_write;
    test_counters;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
